// File: rtl/aes_v3_seq.sv
// Multi-cycle AES round-function unit: byte-select (Inv)SubBytes / (Inv)MixColumn
// plus a whole-word mode that time-shares NSBOX S-box lanes across cycles.

package aes_v3_seq_pkg;

    // Operands captured when a request is accepted.
    typedef struct packed {
        logic        dec;
        logic        mix;
        logic        word;
        logic [1:0]  bs;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } op_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] t;
        t = gf_mul(a, a);
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            r = gf_mul(r, t);
            t = gf_mul(t, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    // Single-byte column contribution, byte 0 of the result is the row-0 coefficient.
    function automatic logic [31:0] mix_byte(input logic [7:0] b, input logic dec);
        if (dec)
            return {gf_mul(b, 8'h0b), gf_mul(b, 8'h0d), gf_mul(b, 8'h09), gf_mul(b, 8'h0e)};
        else
            return {gf_mul(b, 8'h03), b, b, xtime(b)};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w, input logic dec);
        logic [31:0] r;
        logic [7:0]  a0, a1, a2, a3;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            a0 = w[8*i +: 8];
            a1 = w[8*((i+1)%4) +: 8];
            a2 = w[8*((i+2)%4) +: 8];
            a3 = w[8*((i+3)%4) +: 8];
            if (dec)
                r[8*i +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                            ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            else
                r[8*i +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        end
        return r;
    endfunction

    function automatic logic [31:0] rotl_bytes(input logic [31:0] r, input logic [1:0] bs);
        case (bs)
            2'd0:    return r;
            2'd1:    return {r[23:0], r[31:24]};
            2'd2:    return {r[15:0], r[31:16]};
            default: return {r[7:0],  r[31:8]};
        endcase
    endfunction

endpackage

module aes_sbox
    import aes_v3_seq_pkg::*;
(
    input  logic       inv,
    input  logic [7:0] in,
    output logic [7:0] out
);

    assign out = inv ? sbox_inv(in) : sbox_fwd(in);

endmodule

module aes_v3_seq
    import aes_v3_seq_pkg::*;
#(
    parameter int unsigned NSBOX = 1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        valid,
    input  logic        dec,
    input  logic        mix,
    input  logic        word,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [1:0]  bs,
    output logic [31:0] rd,
    output logic        ready
);

    if (!(NSBOX == 1 || NSBOX == 2 || NSBOX == 4)) begin : g_bad_nsbox
        $error("aes_v3_seq: NSBOX must be 1, 2 or 4");
    end

    localparam int unsigned NSTEP = 4 / NSBOX;
    localparam logic [1:0]  LAST  = 2'(NSTEP - 1);

    typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] wreg_q, wreg_d;
    logic [31:0] rd_q, rd_d;
    logic        ready_q, ready_d;

    logic [7:0]  lane_in  [NSBOX];
    logic [7:0]  lane_out [NSBOX];
    logic [1:0]  lane_idx [NSBOX];

    for (genvar g = 0; g < int'(NSBOX); g++) begin : g_lane
        aes_sbox u_sbox (
            .inv (op_q.dec),
            .in  (lane_in[g]),
            .out (lane_out[g])
        );
    end

    // Lane j serves byte cnt*NSBOX+j in word mode; lane 0 serves the selected byte otherwise.
    always_comb begin
        for (int j = 0; j < int'(NSBOX); j++) begin
            lane_idx[j] = 2'(int'(cnt_q) * int'(NSBOX) + j);
            lane_in[j]  = 8'h00;
            if (op_q.word)
                lane_in[j] = op_q.rs1[8*lane_idx[j] +: 8];
            else if (j == 0)
                lane_in[j] = op_q.rs1[8*op_q.bs +: 8];
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= 2'd0;
            wreg_q  <= 32'h0;
            rd_q    <= 32'h0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            wreg_q  <= wreg_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        wreg_d  = wreg_q;
        rd_d    = rd_q;
        ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid) begin
                    op_d.dec  = dec;
                    op_d.mix  = mix;
                    op_d.word = word;
                    op_d.bs   = bs;
                    op_d.rs1  = rs1;
                    op_d.rs2  = rs2;
                    cnt_d     = 2'd0;
                    state_d   = SUB;
                end
            end

            SUB: begin
                if (!valid) begin
                    state_d = IDLE;
                end else if (!op_q.word) begin
                    rd_d    = rotl_bytes(op_q.mix ? mix_byte(op_q.rs1[8*op_q.bs +: 8], op_q.dec)
                                                  : {24'h0, lane_out[0]}, op_q.bs) ^ op_q.rs2;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    for (int j = 0; j < int'(NSBOX); j++)
                        wreg_d[8*lane_idx[j] +: 8] = lane_out[j];
                    if (cnt_q == LAST) begin
                        if (op_q.mix) begin
                            state_d = MIX;
                        end else begin
                            rd_d    = wreg_d ^ op_q.rs2;
                            ready_d = 1'b1;
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            MIX: begin
                if (!valid) begin
                    state_d = IDLE;
                end else begin
                    rd_d    = mix_col(wreg_q, op_q.dec) ^ op_q.rs2;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end

            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd    = rd_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_aes_v3_seq.sv
// Directed self-checking bench for aes_v3_seq at NSBOX = 1, 2 and 4 side by side.

module tb_aes_v3_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  vld;
    logic        dec, mix, word;
    logic [31:0] rs1, rs2;
    logic [1:0]  bs;
    logic [31:0] rd0, rd1, rd2;
    logic [2:0]  rdy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] res_rd  [3];
    int          res_lat [3];

    aes_v3_seq #(.NSBOX(1)) u_dut1 (
        .g_clk(clk), .g_reset(rst), .valid(vld[0]), .dec(dec), .mix(mix), .word(word),
        .rs1(rs1), .rs2(rs2), .bs(bs), .rd(rd0), .ready(rdy[0]));
    aes_v3_seq #(.NSBOX(2)) u_dut2 (
        .g_clk(clk), .g_reset(rst), .valid(vld[1]), .dec(dec), .mix(mix), .word(word),
        .rs1(rs1), .rs2(rs2), .bs(bs), .rd(rd1), .ready(rdy[1]));
    aes_v3_seq #(.NSBOX(4)) u_dut4 (
        .g_clk(clk), .g_reset(rst), .valid(vld[2]), .dec(dec), .mix(mix), .word(word),
        .rs1(rs1), .rs2(rs2), .bs(bs), .rd(rd2), .ready(rdy[2]));

    function automatic logic [31:0] rd_of(input int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one request to all three units; operands are scrambled once accepted.
    task automatic run_op(input logic d, input logic m, input logic w,
                          input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        logic [2:0] pend;
        @(negedge clk);
        dec = d; mix = m; word = w; rs1 = a; rs2 = b; bs = s;
        vld  = 3'b111;
        pend = 3'b111;
        for (int i = 0; i < 3; i++) begin
            res_lat[i] = -1;
            res_rd[i]  = 'x;
        end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 1) begin
                rs1 = ~a; rs2 = ~b; bs = ~s; dec = ~d; mix = ~m; word = ~w;
            end
            for (int i = 0; i < 3; i++) begin
                if (pend[i] && rdy[i]) begin
                    res_lat[i] = cyc;
                    res_rd[i]  = rd_of(i);
                    pend[i]    = 1'b0;
                    vld[i]     = 1'b0;
                end else if (!pend[i] && cyc == res_lat[i] + 1) begin
                    check_eq($sformatf("pulse_nsbox_idx%0d", i), {31'b0, rdy[i]}, 32'h0);
                end
            end
        end
        vld = 3'b000;
    endtask

    task automatic do_vec(input string tag, input logic d, input logic m, input logic w,
                          input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                          input logic [31:0] exp, input int l1, input int l2, input int l4);
        int le [3];
        le = '{l1, l2, l4};
        run_op(d, m, w, a, b, s);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("%s_rd%0d", tag, i), res_rd[i], exp);
            check_eq($sformatf("%s_lat%0d", tag, i), 32'(res_lat[i]), 32'(le[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; vld = 3'b000; dec = 1'b0; mix = 1'b0; word = 1'b0;
        rs1 = 32'h0; rs2 = 32'h0; bs = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ready", {29'b0, rdy}, 32'h0);
        check_eq("reset_rd1", rd0, 32'h0);
        check_eq("reset_rd4", rd2, 32'h0);
        rst = 1'b0;

        //      tag          dec   mix   word  rs1           rs2           bs    expected      lat 1/2/4
        do_vec("b_encmix",  1'b0, 1'b1, 1'b0, 32'h00000100, 32'h00000000, 2'd1, 32'h01010203, 2, 2, 2);
        do_vec("b_decmix",  1'b1, 1'b1, 1'b0, 32'h00000001, 32'h00000000, 2'd0, 32'h0b0d090e, 2, 2, 2);
        do_vec("b_encsub",  1'b0, 1'b0, 1'b0, 32'h00530000, 32'h11111111, 2'd2, 32'h11FC1111, 2, 2, 2);
        do_vec("b_decsub",  1'b1, 1'b0, 1'b0, 32'h00000063, 32'h00000000, 2'd0, 32'h00000000, 2, 2, 2);
        do_vec("w_encsub0", 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 2'd0, 32'h63636363, 5, 3, 2);
        do_vec("w_encmix0", 1'b0, 1'b1, 1'b1, 32'h00000000, 32'hFFFFFFFF, 2'd0, 32'h9C9C9C9C, 6, 4, 3);
        do_vec("w_encmix",  1'b0, 1'b1, 1'b1, 32'h6850829f, 32'h00000000, 2'd2, 32'hbca14d8e, 6, 4, 3);
        do_vec("w_encsub",  1'b0, 1'b0, 1'b1, 32'h6850829f, 32'h00000000, 2'd0, 32'h455313db, 5, 3, 2);
        do_vec("w_decmix0", 1'b1, 1'b1, 1'b1, 32'h63636363, 32'h12345678, 2'd0, 32'h12345678, 6, 4, 3);
        do_vec("w_decsub",  1'b1, 1'b0, 1'b1, 32'h455313db, 32'h00000000, 2'd1, 32'h6850829f, 5, 3, 2);
        do_vec("w_decmix",  1'b1, 1'b1, 1'b1, 32'h6532e319, 32'h0000ffff, 2'd0, 32'h4553EC24, 6, 4, 3);
        do_vec("b_encsub3", 1'b0, 1'b0, 1'b0, 32'h53000000, 32'h00000000, 2'd3, 32'hED000000, 2, 2, 2);

        // Abort: word op on the NSBOX=1 unit, valid dropped in its third SUB cycle.
        @(negedge clk);
        dec = 1'b0; mix = 1'b0; word = 1'b1; rs1 = 32'h0; rs2 = 32'h0; bs = 2'd0;
        vld = 3'b001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vld = 3'b000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("abort_ready_c%0d", c), {31'b0, rdy[0]}, 32'h0);
            check_eq($sformatf("abort_rd_c%0d", c), rd0, 32'hED000000);
        end
        do_vec("post_abort", 1'b0, 1'b1, 1'b0, 32'h00000100, 32'h00000000, 2'd1, 32'h01010203, 2, 2, 2);

        // Synchronous reset while every unit is busy.
        @(negedge clk);
        dec = 1'b0; mix = 1'b1; word = 1'b1; rs1 = 32'h0; rs2 = 32'h0; bs = 2'd0;
        vld = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        vld = 3'b000;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_mid_ready", {29'b0, rdy}, 32'h0);
        check_eq("rst_mid_rd1", rd0, 32'h0);
        check_eq("rst_mid_rd2", rd1, 32'h0);
        check_eq("rst_mid_rd4", rd2, 32'h0);
        rst = 1'b0;
        do_vec("post_rst", 1'b1, 1'b0, 1'b0, 32'h00000063, 32'hA5A5A5A5, 2'd0, 32'hA5A5A5A5, 2, 2, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
